// File: rtl/descaler.sv
// descaler - inverse stage of the approximation datapath.
//
// Undoes the range-normalisation shift applied by the scaler. Scaler flags
// are queued in a small FIFO so that each result leaving the approximation
// core is matched, in order, with the flags of its operand.
//
// Optional feature (macro DESCALER_ROUND_EN):
//   defined     : shift_l path rounds half up, z = (y + 1) >>> 1
//   not defined : shift_l path truncates,       z = y >>> 1
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   flag_valid_i             push {shift_r_i, shift_l_i, no_shift_i} into FIFO
//   y_i/y_valid_i/y_ready_o  signed approximation result handshake
//   z_o/z_valid_o/z_ready_i  signed descaled result handshake
//   fifo_cnt_o               number of queued flag entries
//   err_o                    sticky error (overflowed push or non-one-hot flags)

module descaler #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flag_valid_i,
  input  logic                     shift_r_i,
  input  logic                     shift_l_i,
  input  logic                     no_shift_i,
  input  logic [W-1:0]             y_i,
  input  logic                     y_valid_i,
  output logic                     y_ready_o,
  output logic [W-1:0]             z_o,
  output logic                     z_valid_o,
  input  logic                     z_ready_i,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o,
  output logic                     err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    FLAG_NONE = 2'd0,
    FLAG_R    = 2'd1,
    FLAG_L    = 2'd2
  } flag_e;

  flag_e          mem_q [DEPTH];
  flag_e          mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   z_q, z_d;
  logic           z_valid_q, z_valid_d;
  logic           err_q, err_d;

  logic           full;
  logic           y_ready;
  logic           pop;
  logic           push;
  flag_e          flag_in;
  logic           flag_bad;
  flag_e          head;
  logic [W-1:0]   z_calc;
`ifdef DESCALER_ROUND_EN
  logic [W:0]     round_sum;
`endif

  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    // Registered count only: a flag pushed this cycle cannot be popped yet.
    y_ready = (cnt_q != '0) && (!z_valid_q || z_ready_i);
    pop     = y_valid_i && y_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push    = flag_valid_i && (!full || pop);

    flag_bad = 1'b0;
    unique case ({shift_r_i, shift_l_i, no_shift_i})
      3'b100:  flag_in = FLAG_R;
      3'b010:  flag_in = FLAG_L;
      3'b001:  flag_in = FLAG_NONE;
      default: begin
        flag_in  = FLAG_NONE;
        flag_bad = 1'b1;
      end
    endcase

    head = mem_q[rd_ptr_q];

`ifdef DESCALER_ROUND_EN
    round_sum = '0;
`endif
    unique case (head)
      FLAG_R: begin
        // Doubling overflows exactly when the two top bits differ.
        if (y_i[W-1] != y_i[W-2]) begin
          z_calc = y_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
          z_calc = {y_i[W-2:0], 1'b0};
        end
      end
      FLAG_L: begin
`ifdef DESCALER_ROUND_EN
        round_sum = {y_i[W-1], y_i} + (W+1)'(1);
        z_calc    = round_sum[W:1];
`else
        z_calc = {y_i[W-1], y_i[W-1:1]};
`endif
      end
      default: z_calc = y_i;
    endcase

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = flag_in;
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q
          | (flag_valid_i && full && !pop)
          | (flag_valid_i && flag_bad);

    z_d = pop ? z_calc : z_q;
    if (pop) begin
      z_valid_d = 1'b1;
    end else if (z_ready_i) begin
      z_valid_d = 1'b0;
    end else begin
      z_valid_d = z_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= FLAG_NONE;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      err_q     <= err_d;
    end
  end

  assign y_ready_o  = y_ready;
  assign z_o        = z_q;
  assign z_valid_o  = z_valid_q;
  assign fifo_cnt_o = cnt_q;
  assign err_o      = err_q;

endmodule
